// File: rtl/rom_copier_pkg.sv
// rom_copier shared definitions: FSM encoding and checksum width.
// Imported by rom_copier.
package rom_copier_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CAPT,
      ST_PUSH,
      ST_DONE
   } state_e;

   localparam int CSUM_W = 16;

endpackage

// File: rtl/rom_copier.sv
// rom_copier: boot-time ROM-to-RAM copy sequencer, 3 cycles per word.
// Optional checksum output enabled by defining ROM_COPIER_CHECKSUM_EN.
module rom_copier
   import rom_copier_pkg::*;
#(
   parameter int          DW       = 8,
   parameter int          AW       = 14,
   parameter int          COUNT    = 2**AW,
   parameter int          DST_AW   = 20,
   parameter int unsigned DST_BASE = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rom_ce,
   output logic [AW-1:0]     rom_a,
   input  logic [DW-1:0]     rom_q,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [DST_AW-1:0] wr_addr,
   output logic [DW-1:0]     wr_data
`ifdef ROM_COPIER_CHECKSUM_EN
   ,
   output logic [CSUM_W-1:0] checksum
`endif
);

   // index is one bit wider than rom_a so COUNT == 2**AW ends without wrap
   localparam logic [AW:0]       LAST = (AW+1)'(COUNT-1);
   localparam logic [DST_AW-1:0] BASE = DST_AW'(DST_BASE);

   state_e              state_q, state_d;
   logic [AW:0]         idx_q, idx_d;
   logic                done_q, done_d;
   logic                wvld_q, wvld_d;
   logic [DST_AW-1:0]   waddr_q, waddr_d;
   logic [DW-1:0]       wdata_q, wdata_d;
`ifdef ROM_COPIER_CHECKSUM_EN
   logic [CSUM_W-1:0]   csum_q, csum_d;
`endif

   // Next-state and datapath updates for the copy sequencer
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = done_q;
      wvld_d  = wvld_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
`ifdef ROM_COPIER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               idx_d   = '0;
               done_d  = 1'b0;
`ifdef ROM_COPIER_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_CAPT;
         end
         ST_CAPT: begin
            wdata_d = rom_q;
            wvld_d  = 1'b1;
            waddr_d = BASE + DST_AW'(idx_q);
            state_d = ST_PUSH;
         end
         ST_PUSH: begin
            if (wr_ready) begin
               wvld_d = 1'b0;
`ifdef ROM_COPIER_CHECKSUM_EN
               csum_d = csum_q + CSUM_W'(wdata_q);
`endif
               if (idx_q == LAST) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset; reset aborts a copy
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         done_q  <= 1'b0;
         wvld_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
`ifdef ROM_COPIER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         wvld_q  <= wvld_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
`ifdef ROM_COPIER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // ROM is only enabled in FETCH so its output holds under back-pressure
   assign rom_ce   = (state_q == ST_FETCH);
   assign rom_a    = idx_q[AW-1:0];
   assign busy     = (state_q == ST_FETCH) || (state_q == ST_CAPT) ||
                     (state_q == ST_PUSH);
   assign done     = done_q;
   assign wr_valid = wvld_q;
   assign wr_addr  = waddr_q;
   assign wr_data  = wdata_q;
`ifdef ROM_COPIER_CHECKSUM_EN
   assign checksum = csum_q;
`endif

endmodule
